uart_packet_decoder: RTL

UART_PACKET_DECODER -- requirements
Module: uart_packet_decoder

---
 rtl/uart_packet_decoder.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_packet_decoder.sv
// Decodes 0x7E-framed packets from a UART byte stream, validates the mod-256 checksum,
// then streams the buffered payload out through a valid/ready port.
module uart_packet_decoder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_LEN        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_drdy,
  output logic       pkt_valid,
  output logic [6:0] out_addr,
  output logic       out_write,
  output logic [4:0] out_len,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       err_checksum,
  output logic       err_length,
  output logic       err_timeout,
  output logic       err_overrun,
  output logic       busy
);

  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH = 1 << AW;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] SOF = 8'h7E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_LENGTH,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DRAIN
  } state_t;

  state_t        r_state;
  logic          r_drdy_prev;
  logic [7:0]    r_sum;
  logic [4:0]    r_wr_idx;
  logic [4:0]    r_rd_idx;
  logic [TW-1:0] r_tmo;
  logic [7:0]    r_buf [DEPTH];

  logic          r_pkt_valid;
  logic [6:0]    r_out_addr;
  logic          r_out_write;
  logic [4:0]    r_out_len;
  logic [7:0]    r_out_data;
  logic          r_out_valid;
  logic          r_out_last;
  logic          r_err_checksum;
  logic          r_err_length;
  logic          r_err_timeout;
  logic          r_err_overrun;

  logic          w_strobe;
  logic [7:0]    w_sum_final;
  logic [4:0]    w_wr_next;
  logic [4:0]    w_rd_next;
  logic          w_handshake;
  logic          w_tmo_expired;
  logic          w_len_ok;
  logic          w_buf_we;

  assign w_strobe      = rx_drdy & ~r_drdy_prev;
  assign w_sum_final   = r_sum + rx_data;
  assign w_wr_next     = r_wr_idx + 5'd1;
  assign w_rd_next     = r_rd_idx + 5'd1;
  assign w_handshake   = r_out_valid & out_ready;
  assign w_tmo_expired = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_len_ok      = (rx_data <= 8'(MAX_LEN));
  assign w_buf_we      = w_strobe && (r_state == ST_PAYLOAD);

  // Payload store; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf[r_wr_idx[AW-1:0]] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_drdy_prev    <= 1'b0;
      r_sum          <= 8'h00;
      r_wr_idx       <= 5'd0;
      r_rd_idx       <= 5'd0;
      r_tmo          <= '0;
      r_pkt_valid    <= 1'b0;
      r_out_addr     <= 7'd0;
      r_out_write    <= 1'b0;
      r_out_len      <= 5'd0;
      r_out_data     <= 8'h00;
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;
      r_err_checksum <= 1'b0;
      r_err_length   <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_overrun  <= 1'b0;
    end else begin
      r_drdy_prev    <= rx_drdy;
      r_pkt_valid    <= 1'b0;
      r_err_checksum <= 1'b0;
      r_err_length   <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_overrun  <= 1'b0;

      // The inter-byte timer only runs while a frame is being received.
      if (w_strobe || r_state == ST_IDLE || r_state == ST_DRAIN) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_strobe && rx_data == SOF) begin
            r_state <= ST_HEADER;
          end
        end

        ST_HEADER: begin
          if (w_strobe) begin
            r_out_write <= rx_data[7];
            r_out_addr  <= rx_data[6:0];
            r_sum       <= rx_data;
            r_state     <= ST_LENGTH;
          end else if (w_tmo_expired) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end

        ST_LENGTH: begin
          if (w_strobe) begin
            if (!w_len_ok) begin
              r_err_length <= 1'b1;
              r_state      <= ST_IDLE;
            end else begin
              r_out_len <= rx_data[4:0];
              r_sum     <= w_sum_final;
              r_wr_idx  <= 5'd0;
              r_state   <= (rx_data == 8'h00) ? ST_CHECK : ST_PAYLOAD;
            end
          end else if (w_tmo_expired) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end

        ST_PAYLOAD: begin
          if (w_strobe) begin
            r_sum    <= w_sum_final;
            r_wr_idx <= w_wr_next;
            if (w_wr_next == r_out_len) begin
              r_state <= ST_CHECK;
            end
          end else if (w_tmo_expired) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end

        ST_CHECK: begin
          if (w_strobe) begin
            if (w_sum_final == 8'h00) begin
              // Prime the first beat so out_valid is already up in the pkt_valid cycle.
              r_pkt_valid <= 1'b1;
              r_rd_idx    <= 5'd0;
              r_out_data  <= r_buf[AW'(0)];
              r_out_valid <= (r_out_len != 5'd0);
              r_out_last  <= (r_out_len == 5'd1);
              r_state     <= ST_DRAIN;
            end else begin
              r_err_checksum <= 1'b1;
              r_state        <= ST_IDLE;
            end
          end else if (w_tmo_expired) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end

        ST_DRAIN: begin
          if (w_strobe) begin
            r_err_overrun <= 1'b1;
          end
          if (!r_out_valid) begin
            r_state <= ST_IDLE;
          end else if (w_handshake) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_rd_idx   <= w_rd_next;
              r_out_data <= r_buf[w_rd_next[AW-1:0]];
              r_out_last <= ((w_rd_next + 5'd1) == r_out_len);
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pkt_valid    = r_pkt_valid;
  assign out_addr     = r_out_addr;
  assign out_write    = r_out_write;
  assign out_len      = r_out_len;
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign out_last     = r_out_last;
  assign err_checksum = r_err_checksum;
  assign err_length   = r_err_length;
  assign err_timeout  = r_err_timeout;
  assign err_overrun  = r_err_overrun;
  assign busy         = (r_state != ST_IDLE);

endmodule
